intdiv_seq: RTL and testbench
=============================

INTDIV_SEQ -- requirements
Module: intdiv_seq

Interface
REQ-001 SHALL have parameter LOGN, default 128, dividend/quotient width (= LOGA+LOGB of the multiplier product).
REQ-002 SHALL have parameter LOGD, default 64, divisor/remainder width; LOGD <= LOGN.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operands N, D are valid.
REQ-006 SHALL have port in_ready  output  1  block accepts operands.
REQ-007 SHALL have port N  input  LOGN  unsigned dividend.
REQ-008 SHALL have port D  input  LOGD  unsigned divisor.
REQ-009 SHALL have port out_valid  output  1  Q, R, dbz are valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port Q  output  LOGN  quotient floor(N/D).
REQ-012 SHALL have port R  output  LOGD  remainder N mod D.
REQ-013 SHALL have port dbz  output  1  divide-by-zero flag.

Function
REQ-014 SHALL implement an FSM with states IDLE, CALC, DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE; accept occurs on in_valid&in_ready at a rising edge, latching N and D and moving to CALC.
REQ-016 SHALL perform restoring radix-2 division in CALC, one quotient bit per cycle, MSB first: partial remainder P (LOGD+1 bits) <- {P, next N bit}; if P>=D then P<-P-D and q=1, else q=0.
REQ-017 SHALL spend exactly LOGN cycles in CALC, then enter DONE; out_valid rises LOGN+1 cycles after the accept edge.
REQ-018 SHALL hold Q, R, dbz and out_valid stable in DONE until out_valid&out_ready, then return to IDLE; back-to-back operations are therefore separated by one IDLE cycle.
REQ-019 SHALL ignore in_valid outside IDLE; N and D may change freely after acceptance.
REQ-020 SHALL produce Q = all ones and R = N[LOGD-1:0] for D=0; this matches the natural restoring result with D=0.
REQ-021 SHALL produce Q=0 and R=N for N<D, and Q=N and R=0 for D=1.
REQ-022 SHALL keep out_valid=0 whenever the FSM is not in DONE.

Reset
REQ-023 SHALL on rst assertion, asynchronously and at any state (including mid-CALC), enter IDLE with in_ready=1, out_valid=0, Q=0, R=0, dbz=0, and the internal counter and partial remainder cleared.
REQ-024 SHALL accept no operands while rst is high; an operation in progress is discarded without emitting a result.

Configuration
REQ-025 SHALL support macro INTDIV_DBZ_FAST_EN.
REQ-026 With INTDIV_DBZ_FAST_EN defined, SHALL detect D=0 at acceptance and go directly IDLE->DONE, giving out_valid 1 cycle after accept, dbz=1, and Q/R per REQ-020.
REQ-027 Without INTDIV_DBZ_FAST_EN, SHALL tie dbz to 0 and handle D=0 through the normal LOGN-cycle CALC path, with Q/R per REQ-020.

Structure
REQ-028 SHALL place the FSM state enum and the function intdiv_lat(LOGN) (returns LOGN+1) in shared package intdiv_pkg.
REQ-029 SHALL factor one compare/subtract step into combinational sub-module intdiv_step (inputs P, D; outputs P', q).

Verification (bench LOGN=8, LOGD=4 plus the defaults)
REQ-030 Accept N=100, D=7 -> out_valid at accept+9 cycles, Q=14, R=2, dbz=0.
REQ-031 N=5, D=9 -> Q=0, R=5; N=255, D=1 -> Q=255, R=0.
REQ-032 N=0xA5, D=0 -> Q=0xFF, R=0x5; with INTDIV_DBZ_FAST_EN: dbz=1 at accept+1; without: dbz=0 at accept+9.
REQ-033 Hold out_ready=0 for 5 cycles in DONE -> Q/R/out_valid stable, in_ready=0, a new in_valid is ignored; on the out_ready pulse -> IDLE the next cycle.
REQ-034 Assert rst at CALC cycle 4 -> outputs at reset values immediately; the next operation N=200, D=13 -> Q=15, R=5.
REQ-035 Defaults: 1000 random 128/64-bit pairs streamed with random out_ready -> every Q*D+R==N and R<D, latency = intdiv_lat(128).

Source files
------------

// File: rtl/intdiv_pkg.sv
// intdiv_pkg: FSM encoding and latency helper shared by the divider slice.
// Imported by intdiv_seq and its bench.
package intdiv_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   // Accept edge to first cycle with out_valid visible, in clocks.
   function automatic int intdiv_lat(input int logn);
      return logn + 1;
   endfunction

endpackage

// File: rtl/intdiv_step.sv
// intdiv_step: one restoring compare/subtract step of the divider.
// p is the already-shifted partial remainder, pn the updated remainder.
module intdiv_step #(
   parameter int LOGD = 64
) (
   input  logic [LOGD:0]   p,
   input  logic [LOGD-1:0] d,
   output logic [LOGD-1:0] pn,
   output logic            q
);

   logic [LOGD:0] dx;
   logic [LOGD:0] diff;

   assign dx   = {1'b0, d};
   assign diff = p - dx;
   assign q    = (p >= dx);

   // With d>0 the result is below d and fits LOGD bits; with d=0 the
   // dropped MSB is exactly what the natural restoring result discards.
   assign pn = q ? diff[LOGD-1:0] : p[LOGD-1:0];

endmodule

// File: rtl/intdiv_seq.sv
// intdiv_seq: sequential restoring radix-2 unsigned divider, one bit/cycle.
// Define INTDIV_DBZ_FAST_EN for a one-cycle divide-by-zero path with dbz.
module intdiv_seq
   import intdiv_pkg::*;
#(
   parameter int LOGN = 128,
   parameter int LOGD = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [LOGN-1:0] N,
   input  logic [LOGD-1:0] D,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [LOGN-1:0] Q,
   output logic [LOGD-1:0] R,
   output logic            dbz
);

   localparam int CW = $clog2(LOGN) + 1;
   localparam logic [CW-1:0] LAST = CW'(LOGN - 1);

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [LOGD-1:0] p;
   logic [LOGN-1:0] nq;
   logic [LOGD-1:0] dr;
   logic [LOGD:0]   psh;
   logic [LOGD-1:0] pn;
   logic            qb;

   // nq shifts dividend bits out of the top and quotient bits in below.
   assign psh = {p, nq[LOGN-1]};

   intdiv_step #(
      .LOGD(LOGD)
   ) u_step (
      .p  (psh),
      .d  (dr),
      .pn (pn),
      .q  (qb)
   );

   assign Q = nq;
   assign R = p;

`ifdef INTDIV_DBZ_FAST_EN
   logic dbz_r;

   assign dbz = dbz_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         cnt       <= '0;
         p         <= '0;
         nq        <= '0;
         dr        <= '0;
         dbz_r     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  in_ready <= 1'b0;
                  dr       <= D;
                  cnt      <= '0;
                  if (D == '0) begin
                     nq        <= '1;
                     p         <= N[LOGD-1:0];
                     dbz_r     <= 1'b1;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     nq    <= N;
                     p     <= '0;
                     dbz_r <= 1'b0;
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               p   <= pn;
               nq  <= {nq[LOGN-2:0], qb};
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end
`else
   assign dbz = 1'b0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         cnt       <= '0;
         p         <= '0;
         nq        <= '0;
         dr        <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  in_ready <= 1'b0;
                  dr       <= D;
                  cnt      <= '0;
                  nq       <= N;
                  p        <= '0;
                  state    <= CALC;
               end
            end
            CALC: begin
               p   <= pn;
               nq  <= {nq[LOGN-2:0], qb};
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_intdiv_seq.sv
// tb_intdiv_seq: random and directed checks of intdiv_seq at 8/4 and 128/64.
// Expected results come from plain integer division in the bench.
module tb_intdiv_seq;
   import intdiv_pkg::*;

`ifdef INTDIV_DBZ_FAST_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic       s_iv, s_ir, s_ov, s_or, s_dbz;
   logic [7:0] s_n, s_q;
   logic [3:0] s_d, s_r;

   intdiv_seq #(
      .LOGN(8),
      .LOGD(4)
   ) u_small (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (s_iv),
      .in_ready  (s_ir),
      .N         (s_n),
      .D         (s_d),
      .out_valid (s_ov),
      .out_ready (s_or),
      .Q         (s_q),
      .R         (s_r),
      .dbz       (s_dbz)
   );

   logic [1:0]   b_iv, b_ir, b_ov, b_or, b_dbz;
   logic [127:0] b_n [2];
   logic [127:0] b_q [2];
   logic [63:0]  b_d [2];
   logic [63:0]  b_r [2];

   for (genvar g = 0; g < 2; g++) begin : g_big
      intdiv_seq u_big (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (b_iv[g]),
         .in_ready  (b_ir[g]),
         .N         (b_n[g]),
         .D         (b_d[g]),
         .out_valid (b_ov[g]),
         .out_ready (b_or[g]),
         .Q         (b_q[g]),
         .R         (b_r[g]),
         .dbz       (b_dbz[g])
      );
   end

   function automatic void model(input logic [7:0] n, input logic [3:0] d,
                                 output logic [7:0] q, output logic [3:0] r);
      if (d == 4'd0) begin
         q = 8'hFF;
         r = n[3:0];
      end else begin
         q = n / {4'd0, d};
         r = 4'(n % {4'd0, d});
      end
   endfunction

   task automatic small_op(input logic [7:0] n, input logic [3:0] d,
                           output int lat, output logic acc,
                           output logic [7:0] q, output logic [3:0] r,
                           output logic z);
      @(negedge clk);
      acc  = s_ir;
      s_iv = 1'b1;
      s_n  = n;
      s_d  = d;
      @(posedge clk);
      lat = 0;
      do begin
         @(negedge clk);
         s_iv = 1'b0;
         s_n  = 8'($urandom);
         s_d  = 4'($urandom);
         lat++;
      end while (!s_ov && lat < 64);
      q    = s_q;
      r    = s_r;
      z    = s_dbz;
      s_or = 1'b1;
      @(posedge clk);
      @(negedge clk);
      s_or = 1'b0;
   endtask

   task automatic test_reset();
      s_iv = 0; s_or = 0; s_n = 0; s_d = 0;
      b_iv = 0; b_or = 0;
      for (int i = 0; i < 2; i++) begin
         b_n[i] = '0;
         b_d[i] = '0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if ({s_ir, s_ov, s_dbz} !== 3'b100 || s_q !== 8'd0 || s_r !== 4'd0) begin
         errors++;
         $display("FAIL reset_small: got ir/ov/dbz=%b q=%h r=%h required 100 0 0",
                  {s_ir, s_ov, s_dbz}, s_q, s_r);
      end
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({b_ir[i], b_ov[i], b_dbz[i]} !== 3'b100 || b_q[i] !== '0 || b_r[i] !== '0) begin
            errors++;
            $display("FAIL reset_big%0d: got ir/ov/dbz=%b required 100 with Q=R=0",
                     i, {b_ir[i], b_ov[i], b_dbz[i]});
         end
      end
   endtask

   task automatic test_directed();
      logic [7:0] tn [4] = '{8'd100, 8'd5, 8'd255, 8'hA5};
      logic [3:0] td [4] = '{4'd7, 4'd9, 4'd1, 4'd0};
      logic [7:0] tq [4] = '{8'd14, 8'd0, 8'd255, 8'hFF};
      logic [3:0] tr [4] = '{4'd2, 4'd5, 4'd0, 4'h5};
      int lat, elat;
      logic acc, z, ez;
      logic [7:0] q;
      logic [3:0] r;
      for (int i = 0; i < 4; i++) begin
         small_op(tn[i], td[i], lat, acc, q, r, z);
         elat = (td[i] == 0 && FAST) ? 1 : intdiv_lat(8);
         ez   = (td[i] == 0) && FAST;
         checks++;
         if (q !== tq[i] || r !== tr[i]) begin
            errors++;
            $display("FAIL directed%0d_qr: got q=%h r=%h required q=%h r=%h",
                     i, q, r, tq[i], tr[i]);
         end
         checks++;
         if (lat !== elat || acc !== 1'b1) begin
            errors++;
            $display("FAIL directed%0d_lat: got lat=%0d acc=%b required lat=%0d acc=1",
                     i, lat, acc, elat);
         end
         checks++;
         if (z !== ez) begin
            errors++;
            $display("FAIL directed%0d_dbz: got %b required %b", i, z, ez);
         end
      end
   endtask

   task automatic test_hold();
      int w;
      @(negedge clk);
      s_iv = 1'b1; s_n = 8'd37; s_d = 4'd5;
      @(posedge clk);
      w = 0;
      do begin
         @(negedge clk);
         s_iv = 1'b0;
         w++;
      end while (!s_ov && w < 64);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (s_ov !== 1'b1 || s_ir !== 1'b0 || s_q !== 8'd7 || s_r !== 4'd2) begin
            errors++;
            $display("FAIL hold%0d: got ov=%b ir=%b q=%h r=%h required 1 0 07 2",
                     i, s_ov, s_ir, s_q, s_r);
         end
         s_iv = 1'b1; s_n = 8'h11; s_d = 4'h1;
         @(negedge clk);
      end
      s_iv = 1'b0;
      s_or = 1'b1;
      @(posedge clk);
      @(negedge clk);
      s_or = 1'b0;
      checks++;
      if (s_ov !== 1'b0 || s_ir !== 1'b1) begin
         errors++;
         $display("FAIL hold_release: got ov=%b ir=%b required 0 1", s_ov, s_ir);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      logic acc, z;
      logic [7:0] q;
      logic [3:0] r;
      @(negedge clk);
      s_iv = 1'b1; s_n = 8'd77; s_d = 4'd3;
      @(posedge clk);
      @(negedge clk);
      s_iv = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({s_ir, s_ov, s_dbz} !== 3'b100 || s_q !== 8'd0 || s_r !== 4'd0) begin
         errors++;
         $display("FAIL reset_mid: got ir/ov/dbz=%b q=%h r=%h required 100 00 0",
                  {s_ir, s_ov, s_dbz}, s_q, s_r);
      end
      @(negedge clk);
      s_iv = 1'b1; s_n = 8'd9; s_d = 4'd2;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (s_q !== 8'd0 || s_ov !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_accept: got q=%h ov=%b required 00 0", s_q, s_ov);
      end
      s_iv = 1'b0;
      rst  = 1'b0;
      small_op(8'd200, 4'd13, lat, acc, q, r, z);
      checks++;
      if (q !== 8'd15 || r !== 4'd5 || lat !== intdiv_lat(8)) begin
         errors++;
         $display("FAIL after_reset: got q=%0d r=%0d lat=%0d required 15 5 %0d",
                  q, r, lat, intdiv_lat(8));
      end
   endtask

   task automatic test_random_small();
      int lat, elat;
      logic acc, z;
      logic [7:0] n, q, eq;
      logic [3:0] d, r, er;
      for (int i = 0; i < 40; i++) begin
         n = 8'($urandom);
         d = 4'($urandom);
         model(n, d, eq, er);
         elat = (d == 0 && FAST) ? 1 : intdiv_lat(8);
         small_op(n, d, lat, acc, q, r, z);
         checks++;
         if (q !== eq || r !== er || lat !== elat || z !== (d == 0 && FAST)) begin
            errors++;
            $display("FAIL rand_small n=%0d d=%0d: got q=%0d r=%0d lat=%0d dbz=%b required %0d %0d %0d %b",
                     n, d, q, r, lat, z, eq, er, elat, (d == 0 && FAST));
         end
      end
   endtask

   task automatic big_stream(input int idx, input int cnt);
      logic [127:0] n, eq;
      logic [63:0]  d, er;
      logic [191:0] prod;
      logic         hs;
      int           lat, w;
      for (int k = 0; k < cnt; k++) begin
         n = {$urandom, $urandom, $urandom, $urandom};
         if ($urandom_range(0, 3) == 0) n = n >> $urandom_range(0, 127);
         d = {$urandom, $urandom} >> $urandom_range(0, 63);
         if (d == '0) d = 64'd1;
         eq = n / {64'd0, d};
         er = 64'(n % {64'd0, d});
         @(negedge clk);
         checks++;
         if (b_ir[idx] !== 1'b1) begin
            errors++;
            $display("FAIL big%0d_ready op%0d: got %b required 1", idx, k, b_ir[idx]);
         end
         b_iv[idx] = 1'b1;
         b_n[idx]  = n;
         b_d[idx]  = d;
         @(posedge clk);
         lat = 0;
         do begin
            @(negedge clk);
            b_iv[idx] = 1'b0;
            b_n[idx]  = '0;
            lat++;
         end while (!b_ov[idx] && lat < 400);
         prod = 192'(b_q[idx]) * 192'(d) + 192'(b_r[idx]);
         checks++;
         if (lat !== intdiv_lat(128) || b_q[idx] !== eq || b_r[idx] !== er) begin
            errors++;
            $display("FAIL big%0d_result op%0d: got lat=%0d q=%h r=%h required %0d %h %h",
                     idx, k, lat, b_q[idx], b_r[idx], intdiv_lat(128), eq, er);
         end
         checks++;
         if (prod !== 192'(n) || b_r[idx] >= d || b_dbz[idx] !== 1'b0) begin
            errors++;
            $display("FAIL big%0d_identity op%0d: got q*d+r=%h r=%h required %h r<%h",
                     idx, k, prod, b_r[idx], n, d);
         end
         hs = 1'b0;
         w  = 0;
         while (!hs) begin
            b_or[idx] = ($urandom_range(0, 1) == 1) || (w > 20);
            hs = b_or[idx] && b_ov[idx];
            if (b_q[idx] !== eq || b_ov[idx] !== 1'b1) begin
               checks++;
               errors++;
               $display("FAIL big%0d_stable op%0d: got q=%h ov=%b required %h 1",
                        idx, k, b_q[idx], b_ov[idx], eq);
               hs = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            w++;
         end
         b_or[idx] = 1'b0;
      end
   endtask

   task automatic test_stream_big();
      fork
         big_stream(0, 500);
         big_stream(1, 500);
      join
   endtask

   initial begin
      #8_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_directed();
      test_hold();
      test_reset_mid();
      test_random_small();
      test_stream_big();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
